reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 169 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// Circular reorder buffer that accepts instructions in program order, collects
// their results out of order through a writeback port, and retires them back
// in program order, at most one per cycle, into the register-file commit port.
// Operand lookups use two combinational query ports.
//
// Parameters
//   ROB_DEPTH   entry count; must equal 2**ROB_IDX_W
//   ROB_IDX_W   index width (also the rename tag width)
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   rdy                global enable; every register holds while rdy=0
//   issue_*            in-order allocation at tail; issue_rob_index is the tag
//   rob_full           count==ROB_DEPTH at the start of the cycle
//   wb_*               result writeback by rename tag
//   q1_*, q2_*         operand query (ready flag and value) by rename tag
//   commit_*           registered retire outputs for the register file
//   flush              discard every in-flight entry (branch mispredict)
//
// Optional feature
//   ROB_WB_BYPASS_EN   when defined, the query ports forward a same-cycle
//                      writeback to a valid entry instead of waiting a cycle.
// ---------------------------------------------------------------------------
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,

  input  logic                 issue_valid,
  input  logic                 issue_has_rd,
  input  logic [4:0]           issue_rd,
  output logic [ROB_IDX_W-1:0] issue_rob_index,
  output logic                 rob_full,

  input  logic                 wb_valid,
  input  logic [ROB_IDX_W-1:0] wb_rob_index,
  input  logic [31:0]          wb_value,

  input  logic [ROB_IDX_W-1:0] q1_index,
  input  logic [ROB_IDX_W-1:0] q2_index,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [31:0]          q1_value,
  output logic [31:0]          q2_value,

  output logic                 commit_en,
  output logic [4:0]           commit_reg_index,
  output logic [ROB_IDX_W-1:0] commit_rename,
  output logic [31:0]          commit_value,

  input  logic                 flush
);

  localparam logic [ROB_IDX_W:0]   FULL_COUNT = (ROB_IDX_W+1)'(ROB_DEPTH);
  localparam logic [ROB_IDX_W:0]   COUNT_ONE  = (ROB_IDX_W+1)'(1);
  localparam logic [ROB_IDX_W-1:0] IDX_ONE    = ROB_IDX_W'(1);

  logic [ROB_DEPTH-1:0] ent_valid;
  logic [ROB_DEPTH-1:0] ent_ready;
  logic [ROB_DEPTH-1:0] ent_has_rd;
  logic [4:0]           ent_rd    [ROB_DEPTH];
  logic [31:0]          ent_value [ROB_DEPTH];

  logic [ROB_IDX_W-1:0] head;
  logic [ROB_IDX_W-1:0] tail;
  logic [ROB_IDX_W:0]   count;

  logic do_issue;
  logic do_retire;
  logic do_wb;

  assign issue_rob_index = tail;
  assign rob_full        = (count == FULL_COUNT);

  // Issue is refused whenever the buffer starts the cycle full, even if the
  // head retires on the same edge; this keeps tail from ever overtaking head.
  assign do_issue  = issue_valid && !rob_full;
  assign do_retire = ent_valid[head] && ent_ready[head];
  assign do_wb     = wb_valid && ent_valid[wb_rob_index];

  // Query ports. With the bypass, a writeback landing on a valid entry this
  // cycle is forwarded so dependent instructions need not wait an extra cycle.
  always_comb begin
    q1_ready = ent_valid[q1_index] && ent_ready[q1_index];
    q1_value = ent_value[q1_index];
    q2_ready = ent_valid[q2_index] && ent_ready[q2_index];
    q2_value = ent_value[q2_index];
`ifdef ROB_WB_BYPASS_EN
    if (wb_valid && ent_valid[wb_rob_index] && (wb_rob_index == q1_index)) begin
      q1_ready = 1'b1;
      q1_value = wb_value;
    end
    if (wb_valid && ent_valid[wb_rob_index] && (wb_rob_index == q2_index)) begin
      q2_ready = 1'b1;
      q2_value = wb_value;
    end
`endif
  end

  // Issue, writeback and retire never touch the same entry's valid/ready bits
  // in one cycle: head==tail only when empty (no retire) or full (no issue),
  // and a writeback can only hit the tail slot when that slot is valid (full).
  // Retire reads the value stored at cycle start, so a same-edge writeback to
  // an already-ready head cannot change what is committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid        <= '0;
      ent_ready        <= '0;
      ent_has_rd       <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent_rd[i]    <= 5'd0;
        ent_value[i] <= 32'd0;
      end
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      commit_en        <= 1'b0;
      commit_reg_index <= 5'd0;
      commit_rename    <= '0;
      commit_value     <= 32'd0;
    end else if (rdy) begin
      if (flush) begin
        ent_valid <= '0;
        ent_ready <= '0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        commit_en <= 1'b0;
      end else begin
        if (do_wb) begin
          ent_ready[wb_rob_index] <= 1'b1;
          ent_value[wb_rob_index] <= wb_value;
        end

        if (do_issue) begin
          ent_valid[tail]  <= 1'b1;
          ent_ready[tail]  <= 1'b0;
          ent_has_rd[tail] <= issue_has_rd;
          ent_rd[tail]     <= issue_rd;
          tail             <= tail + IDX_ONE;
        end

        // Writes to x0 and instructions without a destination retire
        // silently: head advances but the register file is not written.
        commit_en <= do_retire && ent_has_rd[head] && (ent_rd[head] != 5'd0);
        if (do_retire) begin
          ent_valid[head]  <= 1'b0;
          head             <= head + IDX_ONE;
          commit_reg_index <= ent_rd[head];
          commit_rename    <= head;
          commit_value     <= ent_value[head];
        end

        case ({do_issue, do_retire})
          2'b10:   count <= count + COUNT_ONE;
          2'b01:   count <= count - COUNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//
// Self-checking bench for reorder_buffer. A reference model keeps the
// in-flight instructions as an ordered queue of records (tag, destination,
// ready, value); the oldest record retires when ready. Directed sequences pin
// the model with literal expectations, then a long randomized run compares
// the DUT against the model on every cycle.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int IW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          issue_valid;
  logic          issue_has_rd;
  logic [4:0]    issue_rd;
  logic [IW-1:0] issue_rob_index;
  logic          rob_full;
  logic          wb_valid;
  logic [IW-1:0] wb_rob_index;
  logic [31:0]   wb_value;
  logic [IW-1:0] q1_index;
  logic [IW-1:0] q2_index;
  logic          q1_ready;
  logic          q2_ready;
  logic [31:0]   q1_value;
  logic [31:0]   q2_value;
  logic          commit_en;
  logic [4:0]    commit_reg_index;
  logic [IW-1:0] commit_rename;
  logic [31:0]   commit_value;
  logic          flush;

  int n_checks = 0;
  int n_errors = 0;

  reorder_buffer #(.ROB_DEPTH(DEPTH), .ROB_IDX_W(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .issue_valid      (issue_valid),
    .issue_has_rd     (issue_has_rd),
    .issue_rd         (issue_rd),
    .issue_rob_index  (issue_rob_index),
    .rob_full         (rob_full),
    .wb_valid         (wb_valid),
    .wb_rob_index     (wb_rob_index),
    .wb_value         (wb_value),
    .q1_index         (q1_index),
    .q2_index         (q2_index),
    .q1_ready         (q1_ready),
    .q2_ready         (q2_ready),
    .q1_value         (q1_value),
    .q2_value         (q2_value),
    .commit_en        (commit_en),
    .commit_reg_index (commit_reg_index),
    .commit_rename    (commit_rename),
    .commit_value     (commit_value),
    .flush            (flush)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered queue of in-flight instructions.
  typedef struct {
    int        idx;
    bit        has_rd;
    bit [4:0]  rd;
    bit        ready;
    bit [31:0] value;
  } ent_t;

  ent_t      mq[$];
  int        m_tail = 0;
  bit        m_cen  = 1'b0;
  bit [4:0]  m_creg = 5'd0;
  bit [IW-1:0] m_cren = '0;
  bit [31:0] m_cval = 32'd0;

`ifdef ROB_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic int find_idx(input int idx);
    foreach (mq[i]) if (mq[i].idx == idx) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkQuery(input string name, input int idx, input logic act_rdy,
                            input logic [31:0] act_val);
    int        p;
    bit        exp_rdy;
    bit [31:0] exp_val;
    p       = find_idx(idx);
    exp_rdy = 1'b0;
    exp_val = 32'd0;
    if (p >= 0) begin
      exp_rdy = mq[p].ready;
      exp_val = mq[p].value;
      if (BYPASS && wb_valid && (int'(wb_rob_index) == idx)) begin
        exp_rdy = 1'b1;
        exp_val = wb_value;
      end
    end
    chk({name, "_ready"}, {31'd0, act_rdy}, {31'd0, exp_rdy});
    if (exp_rdy) chk({name, "_value"}, act_val, exp_val);
  endtask

  // Combinational outputs, checked while this cycle's inputs are stable.
  task automatic checkComb();
    chk("issue_rob_index", {28'd0, issue_rob_index}, m_tail);
    chk("rob_full", {31'd0, rob_full}, {31'd0, mq.size() == DEPTH});
    checkQuery("q1", int'(q1_index), q1_ready, q1_value);
    checkQuery("q2", int'(q2_index), q2_ready, q2_value);
  endtask

  // Registered commit outputs, checked just after the edge.
  task automatic checkOutput();
    chk("commit_en",        {31'd0, commit_en},        {31'd0, m_cen});
    chk("commit_reg_index", {27'd0, commit_reg_index}, {27'd0, m_creg});
    chk("commit_rename",    {28'd0, commit_rename},    {28'd0, m_cren});
    chk("commit_value",     commit_value,              m_cval);
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic modelStep();
    bit   full;
    bit   ret;
    int   p;
    ent_t h;
    if (rst) begin
      mq.delete();
      m_tail = 0;
      m_cen  = 1'b0;
      m_creg = 5'd0;
      m_cren = '0;
      m_cval = 32'd0;
    end else if (rdy) begin
      if (flush) begin
        mq.delete();
        m_tail = 0;
        m_cen  = 1'b0;
      end else begin
        full = (mq.size() == DEPTH);
        ret  = (mq.size() > 0) && mq[0].ready;
        if (ret) h = mq[0];
        if (wb_valid) begin
          p = find_idx(int'(wb_rob_index));
          if (p >= 0) begin
            mq[p].ready = 1'b1;
            mq[p].value = wb_value;
          end
        end
        if (ret) begin
          void'(mq.pop_front());
          m_cen  = h.has_rd && (h.rd != 5'd0);
          m_creg = h.rd;
          m_cren = IW'(h.idx);
          m_cval = h.value;
        end else begin
          m_cen = 1'b0;
        end
        if (issue_valid && !full) begin
          mq.push_back('{idx: m_tail, has_rd: issue_has_rd, rd: issue_rd,
                         ready: 1'b0, value: 32'd0});
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  endtask

  task automatic driveInputs(input bit iv, input bit hrd, input logic [4:0] rd,
                             input bit wv, input logic [IW-1:0] widx,
                             input logic [31:0] wval, input bit fl,
                             input bit r, input bit rs);
    @(negedge clk);
    issue_valid  = iv;
    issue_has_rd = hrd;
    issue_rd     = rd;
    wb_valid     = wv;
    wb_rob_index = widx;
    wb_value     = wval;
    flush        = fl;
    rdy          = r;
    rst          = rs;
    #1;
  endtask

  task automatic finishCycle();
    checkComb();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit iv, input bit hrd, input logic [4:0] rd,
                               input bit wv, input logic [IW-1:0] widx,
                               input logic [31:0] wval, input bit fl,
                               input bit r, input bit rs);
    driveInputs(iv, hrd, rd, wv, widx, wval, fl, r, rs);
    finishCycle();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 5'd0, 0, '0, 32'd0, 0, 1, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 5'd0, 0, '0, 32'd0, 0, 1, 1);
  endtask

  task automatic issue(input bit hrd, input logic [4:0] rd);
    applyStimulus(1, hrd, rd, 0, '0, 32'd0, 0, 1, 0);
  endtask

  task automatic wb(input logic [IW-1:0] idx, input logic [31:0] val);
    applyStimulus(0, 0, 5'd0, 1, idx, val, 0, 1, 0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; issue_has_rd = 1'b0;
    issue_rd = 5'd0; wb_valid = 1'b0; wb_rob_index = '0; wb_value = 32'd0;
    q1_index = '0; q2_index = '0; flush = 1'b0;

    // Reset, single issue, writeback to head, commit on the following edge.
    doReset();
    chk("lit_reset_commit_en", {31'd0, commit_en}, 32'd0);
    chk("lit_reset_commit_value", commit_value, 32'd0);
    chk("lit_reset_tail", {28'd0, issue_rob_index}, 32'd0);
    chk("lit_reset_full", {31'd0, rob_full}, 32'd0);
    issue(1, 5'd5);
    chk("lit_tail_after_issue", {28'd0, issue_rob_index}, 32'd1);
    wb(4'd0, 32'h1234);
    chk("lit_no_commit_on_wb_edge", {31'd0, commit_en}, 32'd0);
    idle();
    chk("lit_commit_en", {31'd0, commit_en}, 32'd1);
    chk("lit_commit_reg", {27'd0, commit_reg_index}, 32'd5);
    chk("lit_commit_rename", {28'd0, commit_rename}, 32'd0);
    chk("lit_commit_value", commit_value, 32'h1234);
    idle();
    chk("lit_commit_en_drops", {31'd0, commit_en}, 32'd0);

    // Fill to capacity; further issues are refused, even on a retire edge.
    doReset();
    for (int i = 0; i < DEPTH; i++) issue(1, 5'(i + 1));
    chk("lit_full", {31'd0, rob_full}, 32'd1);
    chk("lit_full_tail", {28'd0, issue_rob_index}, 32'd0);
    issue(1, 5'd9);
    chk("lit_full_ignored_tail", {28'd0, issue_rob_index}, 32'd0);
    wb(4'd0, 32'hAAAA_0000);
    issue(1, 5'd9);
    chk("lit_retire_from_full", {31'd0, commit_en}, 32'd1);
    chk("lit_not_full_after_retire", {31'd0, rob_full}, 32'd0);
    chk("lit_issue_ignored_on_full_retire", {28'd0, issue_rob_index}, 32'd0);

    // Out-of-order writeback, in-order retire.
    doReset();
    for (int i = 0; i < 3; i++) issue(1, 5'(10 + i));
    wb(4'd2, 32'h22);
    wb(4'd1, 32'h11);
    wb(4'd0, 32'h00);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("lit_ooo_commit_en", {31'd0, commit_en}, 32'd1);
      chk("lit_ooo_rename", {28'd0, commit_rename}, i);
      chk("lit_ooo_reg", {27'd0, commit_reg_index}, 10 + i);
    end

    // Silent retires: no destination, and destination x0.
    doReset();
    issue(0, 5'd7);
    issue(1, 5'd0);
    wb(4'd0, 32'h5);
    wb(4'd1, 32'h6);
    chk("lit_silent0_en", {31'd0, commit_en}, 32'd0);
    chk("lit_silent0_rename", {28'd0, commit_rename}, 32'd0);
    idle();
    chk("lit_silent1_en", {31'd0, commit_en}, 32'd0);
    chk("lit_silent1_rename", {28'd0, commit_rename}, 32'd1);

    // Flush wins over simultaneous issue and writeback.
    doReset();
    for (int i = 0; i < 3; i++) issue(1, 5'(20 + i));
    wb(4'd1, 32'h77);
    q1_index = 4'd1;
    q2_index = 4'd0;
    applyStimulus(1, 1, 5'd3, 1, 4'd0, 32'h99, 1, 1, 0);
    chk("lit_flush_tail", {28'd0, issue_rob_index}, 32'd0);
    chk("lit_flush_commit_en", {31'd0, commit_en}, 32'd0);
    idle();
    chk("lit_flush_q1_ready", {31'd0, q1_ready}, 32'd0);
    chk("lit_flush_q2_ready", {31'd0, q2_ready}, 32'd0);

    // Same-cycle writeback visibility on the query port, then a stall.
    doReset();
    for (int i = 0; i < 4; i++) issue(1, 5'(i + 1));
    q1_index = 4'd3;
    driveInputs(0, 0, 5'd0, 1, 4'd3, 32'hBEEF, 0, 1, 0);
    chk("lit_bypass_ready", {31'd0, q1_ready}, {31'd0, BYPASS});
    if (BYPASS) chk("lit_bypass_value", q1_value, 32'hBEEF);
    finishCycle();
    chk("lit_stored_ready", {31'd0, q1_ready}, 32'd1);
    chk("lit_stored_value", q1_value, 32'hBEEF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 5'd4, 1, 4'd0, 32'h1, 1, 0, 0);
      chk("lit_stall_tail", {28'd0, issue_rob_index}, 32'd4);
      chk("lit_stall_q1", {31'd0, q1_ready}, 32'd1);
    end

    // Randomized traffic against the model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      bit            iv, hrd, wv, fl, r, rs;
      logic [4:0]    rd;
      logic [IW-1:0] widx;
      iv   = ($urandom_range(0, 99) < 55);
      hrd  = ($urandom_range(0, 3) != 0);
      rd   = 5'($urandom);
      wv   = ($urandom_range(0, 99) < 50);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        widx = IW'(mq[$urandom_range(0, mq.size() - 1)].idx);
      else
        widx = IW'($urandom);
      fl   = ($urandom_range(0, 199) == 0);
      r    = ($urandom_range(0, 9) != 0);
      rs   = ($urandom_range(0, 499) == 0);
      q1_index = ($urandom_range(0, 1) == 0) ? widx : IW'($urandom);
      q2_index = IW'($urandom);
      applyStimulus(iv, hrd, rd, wv, widx, $urandom, fl, r, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
